spi_master: RTL and testbench

Frame-level SPI initiator: accepts a parallel request from the host side, shifts it out on MOSI one bit per `clk` under an active-low `ss_n`, and for read requests collects the slave's reply from MISO qualified by `valid_MISO`. It is the master-side counterpart of the slave interface and connects directly to its `ss_n`/`MOSI`/`MISO`/`valid_MISO`/`sready` signals. Both ends share the same `clk`; there is no separate serial clock.

---
 rtl/spi_master.sv | 148 ++++++++++++++
 tb/tb_spi_master.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Frame-level SPI initiator: shifts a request frame out on MOSI under ss_n and optionally collects a reply.
// Optional WAIT timeout/abort path enabled by defining SPI_MASTER_TIMEOUT_EN.
module spi_master #(
  parameter int unsigned FRAME_W = 10,
  parameter int unsigned RESP_W  = 8,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FRAME_W-1:0] req_data,
  input  logic               req_read,
  output logic               rsp_valid,
  output logic [RESP_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               ss_n,
  output logic               MOSI,
  input  logic               MISO,
  input  logic               valid_MISO,
  input  logic               sready
);

  localparam int unsigned FCNT_W = $clog2(FRAME_W + 1);
  localparam int unsigned RCNT_W = $clog2(RESP_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_t;

  state_t              state, next_state;
  logic [FRAME_W-1:0]  tx_q;
  logic                read_q;
  logic [FCNT_W-1:0]   tx_cnt;
  logic [RESP_W-1:0]   rx_q;
  logic [RCNT_W-1:0]   rx_cnt;
  logic [RESP_W-1:0]   rx_next;
  logic                accept;
  logic                frame_end;
  logic                last_capture;
  logic                timed_out;

  assign accept       = (state == IDLE) && req_valid && sready;
  assign frame_end    = (state == SHIFT) && (tx_cnt == FCNT_W'(FRAME_W - 1));
  assign last_capture = (state == WAIT) && valid_MISO && (rx_cnt == RCNT_W'(RESP_W - 1));
  assign rx_next      = RESP_W'({rx_q, MISO});

`ifdef SPI_MASTER_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] wait_cnt;

  // Counts cycles spent in WAIT; a capture on the final allowed cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + TCNT_W'(1);
  end

  assign timed_out = (state == WAIT) && (wait_cnt == TCNT_W'(TIMEOUT - 1)) && !last_capture;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (frame_end) next_state = read_q ? WAIT : DONE;
      WAIT:    if (last_capture || timed_out) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame/reply datapath; rsp_data/rsp_err load on entry to DONE and hold until the next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q     <= '0;
      read_q   <= 1'b0;
      tx_cnt   <= '0;
      rx_q     <= '0;
      rx_cnt   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_q   <= req_data;
            read_q <= req_read;
            tx_cnt <= '0;
            rx_q   <= '0;
            rx_cnt <= '0;
          end
        end
        SHIFT: begin
          tx_q   <= FRAME_W'({tx_q, 1'b0});
          tx_cnt <= tx_cnt + FCNT_W'(1);
          if (frame_end && !read_q) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
          end
        end
        WAIT: begin
          if (valid_MISO) begin
            rx_q   <= rx_next;
            rx_cnt <= rx_cnt + RCNT_W'(1);
          end
          if (last_capture) begin
            rsp_data <= rx_next;
            rsp_err  <= 1'b0;
          end else if (timed_out) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    ss_n      = 1'b1;
    MOSI      = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = sready && !rst;
      end
      SHIFT: begin
        ss_n = 1'b0;
        MOSI = tx_q[FRAME_W-1];
      end
      WAIT:    ss_n = 1'b0;
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: hand-computed vector table, corner sequences and randomized transactions
// against a cycle-count model of the serial protocol (bench acts as the slave).
module tb_spi_master;

  localparam int unsigned FW = 10;
  localparam int unsigned RW = 8;
  localparam int unsigned TO = 32;
  localparam int unsigned VW = 6 + RW;

  logic          clk, rst, req_valid, req_ready, req_read;
  logic [FW-1:0] req_data;
  logic          rsp_valid, rsp_err, busy, ss_n, MOSI, MISO, valid_MISO, sready;
  logic [RW-1:0] rsp_data;

  spi_master #(.FRAME_W(FW), .RESP_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_read(req_read), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .ss_n(ss_n),
    .MOSI(MOSI), .MISO(MISO), .valid_MISO(valid_MISO), .sready(sready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Response as last reported by a DONE cycle (held between completions).
  logic [RW-1:0] m_data = '0;
  logic          m_err  = 1'b0;

  typedef struct {
    string         name;
    logic [FW-1:0] d;
    logic          rd;
    logic [RW-1:0] resp;
    int            dly;
    int            gap;
    int            done;
    logic [RW-1:0] data;
    logic          err;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [VW-1:0] outs();
    return {req_ready, busy, ss_n, MOSI, rsp_valid, rsp_err, rsp_data};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got {rdy,busy,ss_n,mosi,vld,err,data}=%b expected %b", name, act, exp);
    else
      n_pass++;
  endtask

  // Completion cycle/err per protocol rules: WAIT starts at FW+1, DONE follows the last valid bit.
  task automatic model(input logic rd, input int dly, input int gap, output int done, output logic err);
    int last_v;
    last_v = FW + 1 + dly + (RW - 1) * (gap + 1);
    err    = 1'b0;
    if (!rd) done = FW + 1;
    else begin
      done = last_v + 1;
`ifdef SPI_MASTER_TIMEOUT_EN
      if (last_v > FW + TO) begin
        done = FW + 1 + TO;
        err  = 1'b1;
      end
`endif
    end
  endtask

  // One transaction: present request, then check every cycle through the IDLE cycle after DONE.
  task automatic do_txn(input string name, input logic [FW-1:0] d, input logic rd, input logic [RW-1:0] resp,
                        input int dly, input int gap, input int exp_done,
                        input logic [RW-1:0] exp_data, input logic exp_err);
    int first_v, idx;
    logic rdy, ssn, mosi, vld;
    first_v    = FW + 1 + dly;
    req_valid  = 1'b1;
    req_data   = d;
    req_read   = rd;
    sready     = 1'b1;
    valid_MISO = 1'($urandom_range(0, 1));
    MISO       = 1'($urandom_range(0, 1));
    #1;
    check({name, " accept"}, outs(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_err, m_data});
    @(posedge clk);
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(negedge clk);
      rdy  = (k == exp_done + 1) ? sready : 1'b0;
      ssn  = (k >= exp_done);
      mosi = (k <= int'(FW)) ? d[FW-k] : 1'b0;
      vld  = (k == exp_done);
      if (vld) begin
        m_data = exp_data;
        m_err  = exp_err;
      end
      check($sformatf("%s c%0d", name, k), outs(), {rdy, (k <= exp_done), ssn, mosi, vld, m_err, m_data});
      if (k <= exp_done) begin
        req_valid = (k < exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
        req_data  = FW'($urandom);
        req_read  = 1'($urandom_range(0, 1));
        sready    = 1'($urandom_range(0, 1));
        idx       = k - first_v;
        if (rd && k > int'(FW) && k < exp_done) begin
          if (idx >= 0 && idx % (gap + 1) == 0 && idx / (gap + 1) < int'(RW)) begin
            valid_MISO = 1'b1;
            MISO       = resp[RW-1-idx/(gap+1)];
          end else begin
            valid_MISO = 1'b0;
            MISO       = 1'($urandom_range(0, 1));
          end
        end else begin
          valid_MISO = 1'($urandom_range(0, 1));
          MISO       = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  initial begin
    int            done, r_dly, r_gap;
    logic          err, r_rd;
    logic [RW-1:0] r_resp;
    logic [FW-1:0] r_d;

    tbl[0] = '{"wr_2a5",    10'h2A5, 1'b0, 8'h00, 0, 0, 11, 8'h00, 1'b0};
    tbl[1] = '{"rd_a7",     10'h3C0, 1'b1, 8'hA7, 3, 0, 22, 8'hA7, 1'b0};
    tbl[2] = '{"rd_gap_5c", 10'h1FF, 1'b1, 8'h5C, 0, 1, 26, 8'h5C, 1'b0};
    tbl[3] = '{"rd_ff",     10'h000, 1'b1, 8'hFF, 0, 0, 19, 8'hFF, 1'b0};
    tbl[4] = '{"rd_edge",   10'h155, 1'b1, 8'h81, 24, 0, 43, 8'h81, 1'b0};
`ifdef SPI_MASTER_TIMEOUT_EN
    tbl[5] = '{"rd_late",   10'h2AA, 1'b1, 8'h3C, 25, 0, 43, 8'h00, 1'b1};
    tbl[6] = '{"rd_never",  10'h0F0, 1'b1, 8'hE1, 60, 0, 43, 8'h00, 1'b1};
`else
    tbl[5] = '{"rd_late",   10'h2AA, 1'b1, 8'h3C, 25, 0, 44, 8'h3C, 1'b0};
    tbl[6] = '{"rd_hold",   10'h0F0, 1'b1, 8'hE1, 60, 0, 79, 8'hE1, 1'b0};
`endif
    tbl[7] = '{"wr_3ff",    10'h3FF, 1'b0, 8'h00, 0, 0, 11, 8'h00, 1'b0};

    rst = 1'b1; req_valid = 1'b1; req_data = '0; req_read = 1'b0;
    sready = 1'b1; MISO = 1'b0; valid_MISO = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {RW{1'b0}}});
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle", outs(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {RW{1'b0}}});

    foreach (tbl[i])
      do_txn(tbl[i].name, tbl[i].d, tbl[i].rd, tbl[i].resp, tbl[i].dly, tbl[i].gap,
             tbl[i].done, tbl[i].data, tbl[i].err);

    // Slave not ready: request must be held off, then accepted the cycle sready rises.
    req_valid = 1'b1; req_data = 10'h2C3; req_read = 1'b0; sready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("sready_low c%0d", k), outs(), {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_err, m_data});
    end
    do_txn("sready_rise", 10'h2C3, 1'b0, 8'h00, 0, 0, 11, 8'h00, 1'b0);

    // Reset in the middle of SHIFT: no completion for the aborted frame.
    req_valid = 1'b1; req_data = 10'h155; req_read = 1'b1; sready = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    m_data = '0;
    m_err  = 1'b0;
    check("rst_mid", outs(), {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {RW{1'b0}}});
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst c%0d", k), outs(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {RW{1'b0}}});
    end
    do_txn("wr_001", 10'h001, 1'b0, 8'h00, 0, 0, 11, 8'h00, 1'b0);

    for (int t = 0; t < 30; t++) begin
      r_d    = FW'($urandom);
      r_rd   = 1'($urandom_range(0, 3) != 0);
      r_resp = RW'($urandom);
      r_dly  = int'($urandom_range(0, 30));
      r_gap  = int'($urandom_range(0, 3));
      model(r_rd, r_dly, r_gap, done, err);
      do_txn($sformatf("rnd%0d", t), r_d, r_rd, r_resp, r_dly, r_gap, done,
             (r_rd && !err) ? r_resp : RW'(0), err);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
